// File: rtl/power_accum.sv
// power_accum: windowed sum(u*i), sum(u*u), sum(i*i) with Avalon-MM readout; OFFSET_BINARY_EN selects straight-binary inputs
module power_accum #(
  parameter int DW    = 12,
  parameter int ACC_W = 40,
  parameter int WIN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_valid,
  input  logic [DW-1:0]        u_sample,
  input  logic [DW-1:0]        i_sample,
  input  logic [3:0]           address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic                 irq
);
`ifdef OFFSET_BINARY_EN
  localparam logic FLIP = 1'b1;
`else
  localparam logic FLIP = 1'b0;
`endif
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic en, irq_en, done, overrun, v1, v2, hit;
  logic [WIN_W-1:0] window, win_act, count;
  logic signed [DW-1:0] u1, i1;
  logic signed [2*DW-1:0] p_ui, p_uu, p_ii;
  logic signed [ACC_W-1:0] acc_ui, acc_uu, acc_ii, sh_ui, sh_uu, sh_ii;
  logic signed [ACC_W-1:0] sum_ui, sum_uu, sum_ii;
  logic signed [63:0] x_ui, x_uu, x_ii;
  logic [31:0] rd_mux;
  logic wr_status, unused;
  assign wr_status = write && address == 4'd2;
  assign unused = ^writedata[31:WIN_W];
  assign irq = done & irq_en;
  assign sum_ui = acc_ui + ACC_W'(p_ui);
  assign sum_uu = acc_uu + ACC_W'(p_uu);
  assign sum_ii = acc_ii + ACC_W'(p_ii);
  assign hit = state == RUN && en && v2 && count + WIN_W'(1) == win_act;
  assign x_ui = 64'(sh_ui);
  assign x_uu = 64'(sh_uu);
  assign x_ii = 64'(sh_ii);
  // S1 captures (and optionally rebiases) samples, S2 forms the three products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      u1 <= '0;
      i1 <= '0;
      p_ui <= '0;
      p_uu <= '0;
      p_ii <= '0;
    end else begin
      v1 <= sample_valid & en;
      v2 <= v1 & en;
      if (sample_valid) begin
        u1 <= {u_sample[DW-1] ^ FLIP, u_sample[DW-2:0]};
        i1 <= {i_sample[DW-1] ^ FLIP, i_sample[DW-2:0]};
      end
      if (v1) begin
        p_ui <= u1 * i1;
        p_uu <= u1 * u1;
        p_ii <= i1 * i1;
      end
    end
  end
  // S3 accumulation, window boundary handling and status flags (a boundary set beats a same-cycle clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      win_act <= WIN_W'(1);
      count <= '0;
      acc_ui <= '0;
      acc_uu <= '0;
      acc_ii <= '0;
      sh_ui <= '0;
      sh_uu <= '0;
      sh_ii <= '0;
      done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= hit | (done & ~(wr_status & writedata[0]));
      overrun <= (hit & done) | (overrun & ~(wr_status & writedata[1]));
      case (state)
        IDLE: begin
          acc_ui <= '0;
          acc_uu <= '0;
          acc_ii <= '0;
          count <= '0;
          if (en) begin
            state <= RUN;
            win_act <= window;
          end
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
            acc_ui <= '0;
            acc_uu <= '0;
            acc_ii <= '0;
            count <= '0;
          end else if (hit) begin
            sh_ui <= sum_ui;
            sh_uu <= sum_uu;
            sh_ii <= sum_ii;
            acc_ui <= '0;
            acc_uu <= '0;
            acc_ii <= '0;
            count <= '0;
            win_act <= window;
          end else if (v2) begin
            acc_ui <= sum_ui;
            acc_uu <= sum_uu;
            acc_ii <= sum_ii;
            count <= count + WIN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // register file read decode
  always_comb begin
    rd_mux = '0;
    case (address)
      4'd0: rd_mux = {30'b0, irq_en, en};
      4'd1: rd_mux = {{(32-WIN_W){1'b0}}, window};
      4'd2: rd_mux = {30'b0, overrun, done};
      4'd3: rd_mux = x_ui[31:0];
      4'd4: rd_mux = x_ui[63:32];
      4'd5: rd_mux = x_uu[31:0];
      4'd6: rd_mux = x_uu[63:32];
      4'd7: rd_mux = x_ii[31:0];
      4'd8: rd_mux = x_ii[63:32];
      4'd9: rd_mux = {{(32-WIN_W){1'b0}}, count};
      default: rd_mux = '0;
    endcase
  end
  // control registers and registered read data (latency 1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en <= 1'b0;
      irq_en <= 1'b0;
      window <= WIN_W'(1);
      readdata <= '0;
    end else begin
      if (write && address == 4'd0) begin
        en <= writedata[0];
        irq_en <= writedata[1];
      end
      if (write && address == 4'd1)
        window <= writedata[WIN_W-1:0] == '0 ? WIN_W'(1) : writedata[WIN_W-1:0];
      if (read)
        readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_power_accum.sv
// tb_power_accum: table-driven, directed and randomized checks of power_accum against a sum-of-products model
module tb_power_accum;
`ifdef OFFSET_BINARY_EN
  localparam logic [11:0] FLIP = 12'h800;
`else
  localparam logic [11:0] FLIP = 12'h000;
`endif
  logic clk = 0, rst_n = 0, sample_valid = 0, read = 0, write = 0, irq;
  logic [11:0] u_sample = 0, i_sample = 0;
  logic [3:0] address = 0;
  logic [31:0] writedata = 0, readdata, r;
  int checks = 0, errors = 0;
  longint eu, euu, eii;
  logic [11:0] qu[$], qi[$];

  typedef struct {
    int win;
    logic [11:0] u;
    logic [11:0] i;
    longint ui;
    longint uu;
    longint ii;
  } vec_t;
  vec_t tbl[5];

  power_accum dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .u_sample(u_sample),
    .i_sample(i_sample), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic longint conv(input logic [11:0] raw);
    logic signed [11:0] s;
    s = raw ^ FLIP;
    return longint'(s);
  endfunction

  function automatic logic [11:0] enc(input int v);
    logic [11:0] t;
    t = 12'(v);
    return t ^ FLIP;
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1;
    @(posedge clk);
    #1 write = 0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1;
    @(posedge clk);
    #1 read = 0;
    d = readdata;
  endtask

  task automatic send(input logic [11:0] u, input logic [11:0] i);
    @(negedge clk);
    u_sample = u; i_sample = i; sample_valid = 1;
    @(posedge clk);
    #1 sample_valid = 0;
  endtask

  task automatic rd_acc(input logic [3:0] a, output longint v);
    logic [31:0] lo, hi;
    rd(a, lo);
    rd(a + 4'd1, hi);
    v = longint'({hi, lo});
  endtask

  task automatic chk_sums(input string tag, input longint a, input longint b, input longint c);
    longint v;
    rd_acc(4'd3, v); chk({tag, "_ui"}, v, a);
    rd_acc(4'd5, v); chk({tag, "_uu"}, v, b);
    rd_acc(4'd7, v); chk({tag, "_ii"}, v, c);
  endtask

  task automatic restart(input int win, input logic [31:0] ctrl);
    wr(4'd0, 0);
    idle(2);
    wr(4'd1, 32'(win));
    wr(4'd2, 3);
    wr(4'd0, ctrl);
  endtask

  task automatic model(output longint a, output longint b, output longint c);
    a = 0; b = 0; c = 0;
    foreach (qu[k]) begin
      a += conv(qu[k]) * conv(qi[k]);
      b += conv(qu[k]) * conv(qu[k]);
      c += conv(qi[k]) * conv(qi[k]);
    end
  endtask

  task automatic send_rand(input int n);
    logic [11:0] u, i;
    for (int k = 0; k < n; k++) begin
      u = 12'($urandom); i = 12'($urandom);
      qu.push_back(u); qi.push_back(i);
      send(u, i);
    end
  endtask

  initial begin
    tbl[0] = '{1, enc(100), enc(-50), 0, 0, 0};
    tbl[1] = '{3, enc(-2048), enc(2047), 0, 0, 0};
    tbl[2] = '{7, enc(2047), enc(2047), 0, 0, 0};
    tbl[3] = '{1023, enc(-2048), enc(-2048), 0, 0, 0};
    tbl[4] = '{5, enc(0), enc(-1), 0, 0, 0};
    foreach (tbl[k]) begin
      tbl[k].ui = tbl[k].win * conv(tbl[k].u) * conv(tbl[k].i);
      tbl[k].uu = tbl[k].win * conv(tbl[k].u) * conv(tbl[k].u);
      tbl[k].ii = tbl[k].win * conv(tbl[k].i) * conv(tbl[k].i);
    end
    #12;
    chk("rst_irq", irq, 0);
    chk("rst_readdata", readdata, 0);
    @(negedge clk) rst_n = 1;
    rd(4'd0, r); chk("rst_ctrl", r, 0);
    rd(4'd1, r); chk("rst_window", r, 1);
    rd(4'd2, r); chk("rst_status", r, 0);
    rd(4'd9, r); chk("rst_count", r, 0);

    // spec vector: 4 x (100,-50), done/irq exactly 3 clk after the last strobe
    restart(4, 3);
    for (int k = 0; k < 4; k++) send(enc(100), enc(-50));
    @(posedge clk); #1 chk("irq_at_2clk", irq, 0);
    @(posedge clk); #1 chk("irq_at_3clk", irq, 1);
    rd(4'd2, r); chk("status_done", r, 1);
    chk_sums("spec", -20000, 40000, 10000);

    // asynchronous reset mid-window
    rd(4'd5, r);
    send(enc(7), enc(7)); send(enc(7), enc(7));
    @(negedge clk); #2 rst_n = 0;
    #1 chk("async_irq", irq, 0);
    chk("async_readdata", readdata, 0);
    @(negedge clk) rst_n = 1;
    rd(4'd0, r); chk("ar_ctrl", r, 0);
    rd(4'd1, r); chk("ar_window", r, 1);
    rd(4'd2, r); chk("ar_status", r, 0);
    rd(4'd9, r); chk("ar_count", r, 0);
    chk_sums("ar", 0, 0, 0);

    // full-scale pair, window 2
    restart(2, 1);
    send(12'hFFF, 12'h000); send(12'hFFF, 12'h000);
    idle(4);
    qu = {12'hFFF, 12'hFFF}; qi = {12'h000, 12'h000};
    model(eu, euu, eii);
    chk_sums("fs", eu, euu, eii);
`ifdef OFFSET_BINARY_EN
    chk_sums("ob", -8384512, 8380418, 8388608);
    rd(4'd4, r); chk("ob_ui_hi", r, 32'hFFFFFFFF);
`endif

    // overrun: two windows without clearing done
    restart(2, 3);
    qu = {}; qi = {};
    send_rand(4);
    idle(4);
    qu = qu[2:3]; qi = qi[2:3];
    model(eu, euu, eii);
    rd(4'd2, r); chk("ovr_status", r, 3);
    chk_sums("ovr", eu, euu, eii);
    wr(4'd2, 3);
    rd(4'd2, r); chk("ovr_cleared", r, 0);
    chk("ovr_irq_low", irq, 0);

    // WINDOW written mid-run applies from the next boundary
    restart(8, 3);
    qu = {}; qi = {};
    send_rand(5);
    wr(4'd1, 3);
    send_rand(3);
    idle(4);
    model(eu, euu, eii);
    rd(4'd2, r); chk("win8_done", r, 1);
    chk_sums("win8", eu, euu, eii);
    wr(4'd2, 1);
    qu = {}; qi = {};
    send_rand(2);
    idle(4);
    rd(4'd2, r); chk("win3_not_yet", r, 0);
    send_rand(1);
    idle(4);
    rd(4'd2, r); chk("win3_done", r, 1);
    model(eu, euu, eii);
    chk_sums("win3", eu, euu, eii);
    wr(4'd1, 0);
    rd(4'd1, r); chk("win_zero", r, 1);

    // disable mid-window discards partial sums, shadows/status kept
    restart(4, 3);
    send_rand(3);
    idle(3);
    rd(4'd9, r); chk("mid_count", r, 3);
    wr(4'd0, 0);
    idle(3);
    rd(4'd9, r); chk("idle_count", r, 0);
    chk_sums("kept", eu, euu, eii);
    wr(4'd0, 3);
    qu = {}; qi = {};
    send_rand(4);
    idle(4);
    model(eu, euu, eii);
    rd(4'd2, r); chk("reen_done", r, 1);
    chk_sums("reen", eu, euu, eii);

    // table: constant pair over a whole window, boundary widths
    foreach (tbl[k]) begin
      restart(tbl[k].win, 1);
      for (int n = 0; n < tbl[k].win; n++) send(tbl[k].u, tbl[k].i);
      idle(4);
      rd(4'd2, r); chk($sformatf("tbl%0d_done", k), r, 1);
      chk_sums($sformatf("tbl%0d", k), tbl[k].ui, tbl[k].uu, tbl[k].ii);
    end

    // random windows
    for (int t = 0; t < 6; t++) begin
      int w;
      w = int'($urandom_range(1, 20));
      restart(w, 3);
      qu = {}; qi = {};
      send_rand(w);
      idle(4);
      model(eu, euu, eii);
      chk($sformatf("rnd%0d_irq", t), irq, 1);
      chk_sums($sformatf("rnd%0d", t), eu, euu, eii);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/power_accum.md
Name: power_accum

Overview:
- Downstream metering stage fed by the dual ADS805 capture block.
- Takes simultaneous 12-bit voltage/current sample pairs and accumulates sum(u*i) (active power), sum(u*u) and sum(i*i) (RMS terms) over a programmable window.
- At each window end it latches the three sums into shadow registers and raises an irq.
- The Nios CPU reads the results over an Avalon-MM slave port.

Parameters:
- DW, 12, sample width in bits.
- ACC_W, 40, accumulator and shadow-register width in bits.
- WIN_W, 10, window-length register width; maximum window is 1023 samples.

Ports:
- clk  in  1  system clock; sample and bus logic share it.
- rst_n  in  1  asynchronous active-low reset.
- sample_valid  in  1  one-cycle strobe; u_sample/i_sample are valid this cycle.
- u_sample  in  DW  voltage sample.
- i_sample  in  DW  current sample.
- address  in  4  Avalon word address.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; registered, read latency 1.
- irq  out  1  level interrupt = done & irq_en.

Behaviour:
- Reset values: readdata=0, irq=0, all accumulators/shadows/counters=0, CTRL=0, WINDOW=1, STATUS=0.
- Register map:
  - 0 CTRL RW: bit0 enable, bit1 irq_en.
  - 1 WINDOW RW: [WIN_W-1:0]; a written 0 is stored as 1.
  - 2 STATUS: read bit0 done, bit1 overrun; writing 1 to a bit clears it.
  - 3/4 UI lo[31:0] / hi (sign-extended ACC_W-1:32).
  - 5/6 UU lo/hi.
  - 7/8 II lo/hi.
  - 9 COUNT: samples in the current window.
  - Other addresses read 0; writes to read-only addresses are ignored.
- Pipeline, all stages gated by the delayed valid:
  - S1: register the samples as signed.
  - S2: three DW x DW signed products, 2*DW bits each.
  - S3: sign-extend the products to ACC_W and add.
- FSM states:
  - IDLE: enable=0; accumulators and COUNT held at 0; pipeline valids flushed.
  - RUN: on each S3 valid, accumulate and increment COUNT.
  - When COUNT+1 == window_active on an S3 valid:
    - Shadow <= accumulator + product.
    - Accumulators <= 0, COUNT <= 0.
    - done <= 1; if done was already 1, overrun <= 1.
    - window_active <= WINDOW.
- Latency: shadow registers and done update 3 clk after the sample_valid of the last sample in the window.
- WINDOW writes during RUN take effect at the next window boundary only. Entering RUN loads window_active from WINDOW.
- enable cleared mid-window: go to IDLE next cycle; discard the partial sums; shadows and STATUS keep their values.
- A STATUS clear write in the same cycle as a window-end set: the set wins (done stays 1).
- sample_valid on back-to-back cycles is supported at full rate.
- Bit growth: the worst case 2^22 * 1023 < 2^39 fits ACC_W=40 signed, so no saturation is needed.
- Shadow hi/lo are updated atomically in one cycle. Software reads lo then hi between done events.

Optional Feature:
- Macro OFFSET_BINARY_EN.
- Defined: inputs are ADS805 straight-binary. S1 converts each sample to two's complement by inverting the MSB, so 0x800 -> 0, 0x000 -> -2048, 0xFFF -> +2047.
- Not defined: inputs are already two's complement and pass through unchanged.
- Nothing else changes.

Test Plan:
- Reset with rst_n low mid-window -> all registers read 0, WINDOW reads 1, irq=0 asynchronously.
- Two's-complement build; WINDOW=4, CTRL=3; four pairs u=100, i=-50 -> UI=-20000, UU=40000, II=10000; done=1 and irq=1 exactly 3 clk after the 4th strobe.
- OFFSET_BINARY_EN build; WINDOW=2; pairs (0xFFF,0x000) x2 -> UI=-8384512 (hi=0xFFFFFFFF), UU=8380418, II=8388608.
- WINDOW=2, do not clear done; send 4 samples -> overrun=1 and shadows hold the second window; write STATUS=3 -> both cleared, irq drops.
- WINDOW=8; after 5 samples write WINDOW=3 -> first boundary at sample 8, next at 11; WINDOW write of 0 reads back 1.
- Clear enable after 3 of 4 samples, then re-enable and send 4 samples -> shadows reflect only the last 4; COUNT read mid-window matches the samples accepted.
